// File: rtl/gpio_in_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_mmio
//  Description : Memory-mapped GPIO input block. Synchronises and debounces
//                up to 8 pins, latches rising/falling edges in sticky W1C
//                flags and raises a level interrupt. Reads are registered
//                (1-cycle latency, same timing as the data RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_mmio #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4,
  parameter int PAGE      = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      data_addr,
  input  logic             datamem_rd,
  input  logic [3:0]       datamem_wr,
  input  logic [7:0]       data_wr0,
  output logic [31:0]      data_rd,
  input  logic [WIDTH-1:0] gpio_i,
  output logic             irq_o
);

  localparam int              c_CW       = $clog2(DB_CYCLES + 1);
  localparam logic [c_CW-1:0] c_DB_LAST  = c_CW'(DB_CYCLES - 1);
  localparam logic [21:0]     c_PAGE     = 22'(PAGE);
  localparam logic [1:0]      c_OFF_DATA = 2'd0;
  localparam logic [1:0]      c_OFF_RISE = 2'd1;
  localparam logic [1:0]      c_OFF_FALL = 2'd2;
  localparam logic [1:0]      c_OFF_IEN  = 2'd3;

  logic                       w_sel;
  logic                       w_rd_en;
  logic                       w_wr_en;
  logic [1:0]                 w_off;
  logic [WIDTH-1:0]           w_wdata;

  logic [WIDTH-1:0]           r_sync1;
  logic [WIDTH-1:0]           r_sync2;
  logic [WIDTH-1:0]           r_d;
  logic [WIDTH-1:0][c_CW-1:0] r_cnt;
  logic [WIDTH-1:0]           r_rise;
  logic [WIDTH-1:0]           r_fall;
  logic [WIDTH-1:0]           r_ien;
  logic [31:0]                r_data_rd;

  logic [WIDTH-1:0][c_CW-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]           w_d_nxt;
  logic [WIDTH-1:0]           w_rise_set;
  logic [WIDTH-1:0]           w_fall_set;
  logic [WIDTH-1:0]           w_rise_clr;
  logic [WIDTH-1:0]           w_fall_clr;
  logic [WIDTH-1:0]           w_rd_val;

  // Address bits outside the page/offset decode and the upper byte enables
  // are deliberately ignored (registers alias across the page).
  logic w_unused_bus;
  assign w_unused_bus = ^{data_addr[9:4], data_addr[1:0], datamem_wr[3:1]};

  generate
    if (WIDTH < 8) begin : g_wdata_pad
      logic w_unused_wdata;
      assign w_unused_wdata = ^data_wr0[7:WIDTH];
    end
  endgenerate

  assign w_sel   = (data_addr[31:10] == c_PAGE);
  assign w_off   = data_addr[3:2];
  assign w_rd_en = w_sel & datamem_rd;
  assign w_wr_en = w_sel & datamem_wr[0];
  assign w_wdata = data_wr0[WIDTH-1:0];

  assign w_rise_clr = (w_wr_en && (w_off == c_OFF_RISE)) ? w_wdata : '0;
  assign w_fall_clr = (w_wr_en && (w_off == c_OFF_FALL)) ? w_wdata : '0;

  // Per-pin debounce: accept the synchronised level only after it has
  // differed from the accepted value for DB_CYCLES consecutive cycles.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_d_nxt    = r_d;
    w_rise_set = '0;
    w_fall_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] == r_d[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == c_DB_LAST) begin
        w_d_nxt[i]    = r_sync2[i];
        w_cnt_nxt[i]  = '0;
        w_rise_set[i] = r_sync2[i];
        w_fall_set[i] = ~r_sync2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + c_CW'(1);
      end
    end
  end

  // Register read mux; uses current (pre-write) register values.
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      c_OFF_DATA: w_rd_val = r_d;
      c_OFF_RISE: w_rd_val = r_rise;
      c_OFF_FALL: w_rd_val = r_fall;
      c_OFF_IEN:  w_rd_val = r_ien;
      default:    w_rd_val = '0;
    endcase
  end

  // Two-flop synchroniser on the asynchronous pins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state: accepted value and per-pin run-length counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d   <= '0;
      r_cnt <= '0;
    end else begin
      r_d   <= w_d_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Sticky edge flags (a new edge beats a same-cycle clear) and IEN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rise <= '0;
      r_fall <= '0;
      r_ien  <= '0;
    end else begin
      r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
      r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
      if (w_wr_en && (w_off == c_OFF_IEN)) begin
        r_ien <= w_wdata;
      end
    end
  end

  // Registered read data; returns zero when this block is not being read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data_rd <= '0;
    end else if (w_rd_en) begin
      r_data_rd <= {{(32-WIDTH){1'b0}}, w_rd_val};
    end else begin
      r_data_rd <= '0;
    end
  end

  assign data_rd = r_data_rd;
  assign irq_o   = |((r_rise | r_fall) & r_ien);

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_in_mmio
//  Description : Self-checking bench for gpio_in_mmio: directed vector table,
//                hand-written corner sequences and randomized traffic checked
//                against a window-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_in_mmio;

  localparam int c_DB = 4;

  logic        clk;
  logic        rstn;
  logic [31:0] data_addr;
  logic        datamem_rd;
  logic [3:0]  datamem_wr;
  logic [7:0]  data_wr0;
  logic [31:0] data_rd;
  logic [7:0]  gpio_i;
  logic        irq_o;

  int checks;
  int errors;

  gpio_in_mmio #(
    .WIDTH     (8),
    .DB_CYCLES (c_DB),
    .PAGE      (2)
  ) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_addr  (data_addr),
    .datamem_rd (datamem_rd),
    .datamem_wr (datamem_wr),
    .data_wr0   (data_wr0),
    .data_rd    (data_rd),
    .gpio_i     (gpio_i),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pin's accepted value flips once the last DB synchronised
  // samples all disagree with it.
  logic [7:0]  m_sync1, m_sync2, m_d, m_rise, m_fall, m_ien;
  logic [7:0]  m_win [c_DB];
  logic [31:0] m_rd;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [3:0]  wr;
    logic [7:0]  wdata;
    logic [7:0]  gpio;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic logic m_irq();
    return |((m_rise | m_fall) & m_ien);
  endfunction

  task automatic model_reset();
    m_sync1 = '0; m_sync2 = '0; m_d = '0;
    m_rise  = '0; m_fall  = '0; m_ien = '0; m_rd = '0;
    for (int j = 0; j < c_DB; j++) m_win[j] = '0;
  endtask

  task automatic model_edge();
    logic       sel;
    logic [1:0] off;
    logic [7:0] regv, nd, clr_r, clr_f;
    logic       differs;
    sel = (data_addr[31:10] == 22'd2);
    off = data_addr[3:2];
    case (off)
      2'd0:    regv = m_d;
      2'd1:    regv = m_rise;
      2'd2:    regv = m_fall;
      default: regv = m_ien;
    endcase
    m_rd = (sel && datamem_rd) ? {24'd0, regv} : 32'd0;
    for (int j = 0; j < c_DB - 1; j++) m_win[j] = m_win[j+1];
    m_win[c_DB-1] = m_sync2;
    nd = m_d;
    for (int i = 0; i < 8; i++) begin
      differs = 1'b1;
      for (int j = 0; j < c_DB; j++)
        if (m_win[j][i] == m_d[i]) differs = 1'b0;
      if (differs) nd[i] = ~m_d[i];
    end
    clr_r = (sel && datamem_wr[0] && off == 2'd1) ? data_wr0 : 8'd0;
    clr_f = (sel && datamem_wr[0] && off == 2'd2) ? data_wr0 : 8'd0;
    m_rise = (m_rise & ~clr_r) | (nd & ~m_d);
    m_fall = (m_fall & ~clr_f) | (~nd & m_d);
    if (sel && datamem_wr[0] && off == 2'd3) m_ien = data_wr0;
    m_d     = nd;
    m_sync2 = m_sync1;
    m_sync1 = gpio_i;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic [31:0] a, input logic r, input logic [3:0] w,
                      input logic [7:0] wd, input logic [7:0] g);
    data_addr  = a;
    datamem_rd = r;
    datamem_wr = w;
    data_wr0   = wd;
    gpio_i     = g;
    @(posedge clk);
    model_edge();
    #1;
    check("model_rd", data_rd, m_rd);
    check("model_irq", {31'd0, irq_o}, {31'd0, m_irq()});
  endtask

  task automatic idle(input logic [7:0] g, input int n);
    for (int k = 0; k < n; k++) step(32'h0, 1'b0, 4'h0, 8'h00, g);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic r, input logic [3:0] w,
                              input logic [7:0] wd, input logic [7:0] g,
                              input logic [31:0] er, input logic ei);
    vec_t v;
    v.addr = a; v.rd = r; v.wr = w; v.wdata = wd; v.gpio = g;
    v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  g;
    logic [31:0] a;
    checks = 0;
    errors = 0;

    // Directed table (rows are consecutive clocks).
    vecs.push_back(mk(32'h800, 1, 4'h0, 8'h00, 8'h00, 32'h0, 0));
    vecs.push_back(mk(32'h804, 1, 4'h0, 8'h00, 8'h00, 32'h0, 0));
    vecs.push_back(mk(32'h808, 1, 4'h0, 8'h00, 8'h00, 32'h0, 0));
    vecs.push_back(mk(32'h80C, 1, 4'h0, 8'h00, 8'h00, 32'h0, 0));
    for (int k = 1; k <= 6; k++)   // edges 1..6: D updates at edge 6, read is pre-edge
      vecs.push_back(mk(32'h800, 1, 4'h0, 8'h00, 8'h05, 32'h0, 0));
    vecs.push_back(mk(32'h800, 1, 4'h0, 8'h00, 8'h05, 32'h05, 0));
    vecs.push_back(mk(32'h804, 1, 4'h0, 8'h00, 8'h05, 32'h05, 0));
    vecs.push_back(mk(32'hBFB, 1, 4'h0, 8'h00, 8'h05, 32'h00, 0));   // aliased FALL
    for (int k = 0; k < 3; k++)    // 3-cycle glitch on pin 3
      vecs.push_back(mk(32'h800, 1, 4'h0, 8'h00, 8'h0D, 32'h05, 0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(32'h800, 1, 4'h0, 8'h00, 8'h05, 32'h05, 0));
    vecs.push_back(mk(32'h804, 1, 4'h0, 8'h00, 8'h05, 32'h05, 0));
    vecs.push_back(mk(32'h80C, 0, 4'h1, 8'h01, 8'h05, 32'h00, 1));   // IEN=1
    vecs.push_back(mk(32'h804, 0, 4'h1, 8'h01, 8'h05, 32'h00, 0));   // clear RISE[0]
    vecs.push_back(mk(32'h804, 1, 4'h0, 8'h00, 8'h05, 32'h04, 0));
    vecs.push_back(mk(32'h404, 1, 4'h0, 8'h00, 8'h05, 32'h00, 0));   // other page
    vecs.push_back(mk(32'h80C, 0, 4'h2, 8'hFF, 8'h05, 32'h00, 0));   // lane 1 only
    vecs.push_back(mk(32'h80C, 1, 4'h0, 8'h00, 8'h05, 32'h01, 0));
    vecs.push_back(mk(32'h80C, 1, 4'h1, 8'h04, 8'h05, 32'h01, 1));   // rd+wr: old value
    vecs.push_back(mk(32'h80C, 1, 4'h0, 8'h00, 8'h05, 32'h04, 1));
    vecs.push_back(mk(32'h804, 0, 4'h1, 8'hFF, 8'h05, 32'h00, 0));

    data_addr = '0; datamem_rd = 0; datamem_wr = '0; data_wr0 = '0; gpio_i = '0;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd", data_rd, 32'h0);
    check("reset_irq", {31'd0, irq_o}, 32'h0);
    rstn = 1'b1;

    foreach (vecs[n]) begin
      step(vecs[n].addr, vecs[n].rd, vecs[n].wr, vecs[n].wdata, vecs[n].gpio);
      check($sformatf("vec%0d_rd", n), data_rd, vecs[n].exp_rd);
      check($sformatf("vec%0d_irq", n), {31'd0, irq_o}, {31'd0, vecs[n].exp_irq});
    end

    // Set beats a same-cycle W1C.
    step(32'h80C, 0, 4'h1, 8'h01, 8'h05);
    idle(8'h04, 8);
    check("fall_irq", {31'd0, irq_o}, 32'h1);
    step(32'h808, 0, 4'h1, 8'hFF, 8'h04);
    check("fall_clr_irq", {31'd0, irq_o}, 32'h0);
    idle(8'h05, 5);
    check("pre_rise_irq", {31'd0, irq_o}, 32'h0);
    step(32'h804, 0, 4'h1, 8'h01, 8'h05);
    check("setwins_irq", {31'd0, irq_o}, 32'h1);
    step(32'h804, 1, 4'h0, 8'h00, 8'h05);
    check("setwins_rise", data_rd, 32'h01);

    // Reset in the middle of a debounce count with flags and IEN set.
    idle(8'h07, 4);
    step(32'h804, 1, 4'h0, 8'h00, 8'h07);
    check("prerst_rd", data_rd, 32'h01);
    rstn = 1'b0;
    model_reset();
    #1;
    check("midrst_rd", data_rd, 32'h0);
    check("midrst_irq", {31'd0, irq_o}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int k = 1; k <= 6; k++) step(32'h804, 1, 4'h0, 8'h00, 8'h07);
    check("postrst_rise_e6", data_rd, 32'h00);
    step(32'h804, 1, 4'h0, 8'h00, 8'h07);
    check("postrst_rise_e7", data_rd, 32'h07);
    step(32'h80C, 1, 4'h0, 8'h00, 8'h07);
    check("postrst_ien", data_rd, 32'h00);

    // Randomized traffic against the model.
    g = 8'h07;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 5) == 0) g = g ^ 8'($urandom);
      a = {22'($urandom_range(0, 4) == 0 ? 1 : 2), 10'($urandom)};
      step(a, 1'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
           8'($urandom), g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
